// File: rtl/bmem_arbiter_pkg.sv
// Shared sizing, FSM state type and address helper for the bmem arbiter.
// Used by bmem_arbiter and bmem_arb_picker.
package bmem_arbiter_pkg;

  localparam int unsigned LINE_WIDTH       = 256;
  localparam int unsigned BEAT_WIDTH       = 64;
  localparam int unsigned BMEM_BEATS       = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned LINE_OFFSET_BITS = 5;
  localparam int unsigned ADDR_WIDTH       = 32;
  localparam int unsigned NUM_PORTS        = 2;
  localparam int unsigned CNT_WIDTH        = $clog2(BMEM_BEATS);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_BURST,
    RESP
  } arb_state_t;

  // Clears the byte-in-line offset so every burst starts on a line boundary.
  function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
    return {addr[ADDR_WIDTH-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/bmem_arb_picker.sv
// Winner select between the two cache ports, holding the last-grant pointer.
// BMEM_ARB_RR_EN defined: round-robin on ties; undefined: port 1 always wins ties.
module bmem_arb_picker
  import bmem_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] rd_req,
  input  logic [NUM_PORTS-1:0] wr_req,
  input  logic                 take,
  output logic                 any_c,
  output logic                 winner_c
);

  logic [NUM_PORTS-1:0] req;

  assign req   = rd_req | wr_req;
  assign any_c = |req;

`ifdef BMEM_ARB_RR_EN
  logic last;

  // Reset to port 1 so that port 0 takes the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (take) begin
      last <= winner_c;
    end
  end

  assign winner_c = (req == 2'b11) ? ~last : req[1];
`else
  logic unused_rr;

  assign unused_rr = ^{clk, rst, take};
  assign winner_c  = req[1];
`endif

endmodule

// File: rtl/bmem_arbiter.sv
// Shares the single bmem port between icache (port 0) and dcache (port 1), one line at a time.
// Arbitration mode follows BMEM_ARB_RR_EN (see bmem_arb_picker); default build is fixed priority.
module bmem_arbiter
  import bmem_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] dfp_addr  [NUM_PORTS],
  input  logic [NUM_PORTS-1:0]  dfp_read,
  input  logic [NUM_PORTS-1:0]  dfp_write,
  input  logic [LINE_WIDTH-1:0] dfp_wdata [NUM_PORTS],
  output logic [LINE_WIDTH-1:0] dfp_rdata,
  output logic [NUM_PORTS-1:0]  dfp_resp,
  output logic [ADDR_WIDTH-1:0] bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [BEAT_WIDTH-1:0] bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [ADDR_WIDTH-1:0] bmem_raddr,
  input  logic [BEAT_WIDTH-1:0] bmem_rdata,
  input  logic                  bmem_rvalid
);

  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BMEM_BEATS - 1);

  arb_state_t            state, state_d;
  logic [CNT_WIDTH-1:0]  cnt, cnt_d;
  logic                  port_q, port_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  read_d, write_d;
  logic [BEAT_WIDTH-1:0] bwdata_d;
  logic [NUM_PORTS-1:0]  resp_d;
  logic [LINE_WIDTH-1:0] rdata_d;
  logic                  take_c, any_c, winner_c;
  logic                  beat_hit_c;
  logic                  unused_bits;

  assign unused_bits = ^{bmem_raddr[LINE_OFFSET_BITS-1:0],
                         dfp_addr[0][LINE_OFFSET_BITS-1:0],
                         dfp_addr[1][LINE_OFFSET_BITS-1:0]};

  bmem_arb_picker u_picker (
    .clk      (clk),
    .rst      (rst),
    .rd_req   (dfp_read),
    .wr_req   (dfp_write),
    .take     (take_c),
    .any_c    (any_c),
    .winner_c (winner_c)
  );

  // Returned beat belongs to the outstanding line only if its line address matches.
  assign beat_hit_c = bmem_rvalid &&
                      (bmem_raddr[ADDR_WIDTH-1:LINE_OFFSET_BITS] == bmem_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS]);

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    port_d   = port_q;
    wdata_d  = wdata_q;
    addr_d   = bmem_addr;
    read_d   = 1'b0;
    write_d  = 1'b0;
    bwdata_d = bmem_wdata;
    resp_d   = '0;
    rdata_d  = dfp_rdata;
    take_c   = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_c) begin
          take_c  = 1'b1;
          port_d  = winner_c;
          addr_d  = line_align(dfp_addr[winner_c]);
          wdata_d = dfp_wdata[winner_c];
          cnt_d   = '0;
          // A port raising read and write together is treated as a write.
          if (dfp_write[winner_c]) begin
            state_d  = WR_BURST;
            write_d  = 1'b1;
            bwdata_d = dfp_wdata[winner_c][BEAT_WIDTH-1:0];
          end else begin
            state_d = RD_REQ;
            read_d  = 1'b1;
          end
        end
      end
      RD_REQ: begin
        if (bmem_ready) begin
          state_d = RD_WAIT;
        end else begin
          read_d = 1'b1;
        end
      end
      RD_WAIT: begin
        if (beat_hit_c) begin
          rdata_d[32'(cnt) * BEAT_WIDTH +: BEAT_WIDTH] = bmem_rdata;
          cnt_d = cnt + CNT_WIDTH'(1);
          if (cnt == LAST_BEAT) begin
            state_d        = RESP;
            resp_d[port_q] = 1'b1;
          end
        end
      end
      WR_BURST: begin
        write_d = 1'b1;
        if (bmem_ready) begin
          cnt_d    = cnt + CNT_WIDTH'(1);
          bwdata_d = wdata_q[32'(cnt_d) * BEAT_WIDTH +: BEAT_WIDTH];
          if (cnt == LAST_BEAT) begin
            state_d        = RESP;
            write_d        = 1'b0;
            resp_d[port_q] = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      port_q     <= 1'b0;
      wdata_q    <= '0;
      bmem_addr  <= '0;
      bmem_read  <= 1'b0;
      bmem_write <= 1'b0;
      bmem_wdata <= '0;
      dfp_resp   <= '0;
      dfp_rdata  <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      port_q     <= port_d;
      wdata_q    <= wdata_d;
      bmem_addr  <= addr_d;
      bmem_read  <= read_d;
      bmem_write <= write_d;
      bmem_wdata <= bwdata_d;
      dfp_resp   <= resp_d;
      dfp_rdata  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(|(dfp_read & dfp_write)))
        else $error("bmem_arbiter: a port raised dfp_read and dfp_write together");
    end
  end

endmodule

// File: doc/bmem_arbiter.md
# bmem_arbiter

Controller that shares the single banked-memory (bmem) port between the instruction cache (port 0) and data cache (port 1). It arbitrates whole-line requests, sequences the 4-beat 64-bit bmem bursts, assembles read bursts into 256-bit lines, and serializes write-back lines. It sits between the caches' dfp interfaces and the top-level bmem pins, and replaces the ad-hoc bmem handshake in the fetch logic. One transaction is outstanding at a time.

## Interface
- LINE_WIDTH, 256, cache line bits
- BEAT_WIDTH, 64, bmem data bits; BEATS = LINE_WIDTH/BEAT_WIDTH = 4
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- dfp_addr[2]  in  32  line address per port; bits [4:0] ignored
- dfp_read[2]  in  1  read-line request, held until dfp_resp
- dfp_write[2]  in  1  write-line request, held until dfp_resp
- dfp_wdata[2]  in  256  write line, stable while dfp_write is high
- dfp_rdata  out  256  assembled read line, shared by both ports
- dfp_resp[2]  out  1  one-cycle completion pulse to the granted port
- bmem_addr  out  32  burst address, {addr[31:5], 5'b0}
- bmem_read  out  1  read command
- bmem_write  out  1  write beat valid
- bmem_wdata  out  64  write beat data
- bmem_ready  in  1  memory accepts command/beat
- bmem_raddr  in  32  address tag of returned beat
- bmem_rdata  in  64  returned beat
- bmem_rvalid  in  1  returned beat valid

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_BURST, RESP.
- IDLE: sample requests; pick a winner (see Configuration); latch port, address, and wdata. Go to WR_BURST if the winner's dfp_write is set, else RD_REQ. Do nothing when no request is pending.
- A port asserting read and write together is illegal. Write wins; the simulation assertion fires.
- RD_REQ: drive bmem_read=1 with bmem_addr. When bmem_ready=1, go to RD_WAIT; otherwise hold the command.
- RD_WAIT: bmem_read=0. Each bmem_rvalid beat whose bmem_raddr[31:5] matches the latched address goes into line[64*cnt +: 64], then cnt++. Non-matching beats are ignored. After beat 3, go to RESP.
- WR_BURST: bmem_write=1, bmem_addr is held, bmem_wdata = wdata[64*cnt +: 64]. cnt advances only on bmem_ready=1. After beat 3 is accepted, go to RESP.
- RESP: dfp_resp[port]=1 for exactly one cycle, with dfp_rdata valid on reads; then go to IDLE.
- Requesters deassert in the cycle after dfp_resp. IDLE samples the updated requests.
- bmem_rvalid outside RD_WAIT is ignored.
- cnt is 2 bits and wraps to 0 on entering RESP.

## Timing
- All bmem_* and dfp_* outputs are registered from state, with no combinational input-to-output paths.
- Reset values:
  - state=IDLE, cnt=0
  - bmem_read=0, bmem_write=0, bmem_addr=0, bmem_wdata=0
  - dfp_resp=0, dfp_rdata=0
  - round-robin pointer set so port 0 wins the first tie
- rst mid-transaction aborts immediately. No dfp_resp is issued, and outputs go to their reset values next cycle.
- Read latency: request seen at cycle 0, bmem_read at cycle 1, resp 1 cycle after the 4th matching rvalid.
- Write latency, with bmem_ready constantly high: beats at cycles 1–4, resp at cycle 5. Each ready-low cycle adds one cycle.
- Minimum gap between back-to-back transactions is one IDLE cycle.

## Configuration
- BMEM_ARB_RR_EN defined: round-robin arbitration. On a tie, the port not granted last wins; the pointer updates on every grant.
- BMEM_ARB_RR_EN undefined: fixed priority, port 1 (dcache) always wins ties. The pointer logic is removed.
- Single-requester behavior is identical in both modes.

## Structure
- Add to rv32i_types:
  - arb_state_t enum (IDLE, RD_REQ, RD_WAIT, WR_BURST, RESP)
  - constants BMEM_BEATS=4 and LINE_OFFSET_BITS=5
- One sub-module, bmem_arb_picker: combinational winner select from the two request vectors plus last-grant pointer, with the pointer register inside. Compiled for both modes; the RR logic sits under the macro.
- Beat counter, line assembly, and FSM stay in the top module.

## Test plan
- Port 0 reads 0x1000_0020, memory returns beats A,B,C,D → bmem_read for 1 cycle with addr 0x1000_0020; dfp_rdata={D,C,B,A}; dfp_resp[0] pulses once.
- Port 1 writes 0x2000_0040 with line {W3,W2,W1,W0}, bmem_ready low for 2 cycles mid-burst → bmem_wdata W0..W3 in order, each held while not ready; resp at cycle 7.
- Both ports request reads in the same cycle, repeated 3 times → RR mode: grants 0,1,0,1,...; fixed mode: port 1 always served first.
- Stray bmem_rvalid in IDLE and a beat with mismatched bmem_raddr during RD_WAIT → both ignored; line built only from matching beats.
- rst asserted on beat 2 of a write → bmem_write=0 next cycle, no dfp_resp; a fresh read afterwards completes normally.
